// File: rtl/snr_pkg.sv
// Shared types and defaults for the SNR measurement sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snr_pkg;

    // Sequencer phases: calibrate noise floor, let filters settle, then average.
    typedef enum logic [2:0] {
        IDLE,
        CALIBRATE,
        SETTLE,
        MEASURE,
        REPORT
    } snr_state_t;

    // snr_db is Q8.8 dB.
    localparam int SNR_FRAC_BITS = 8;

    localparam int DEF_CAL_SAMPLES    = 4096;
    localparam int DEF_SETTLE_SAMPLES = 64;
    localparam int DEF_WINDOW_LOG2    = 8;

endpackage

// File: rtl/snr_measurement_sequencer_if.sv
// Bus bundle between the SNR sequencer, the calculator tap and the result consumer.
// Latency: n/a (wires only).
// Backpressure: result_ready stalls the result handshake; sample_* are observed only.
// Optional macro SNR_SEQ_THRESHOLD_EN adds snr_min (to sequencer) and snr_low (from sequencer).
// Modports: master = sequencer side, slave = calculator tap / display side.
interface snr_measurement_sequencer_if #(
    parameter int SNR_WIDTH = 16
);
    logic                        sample_valid;
    logic                        sample_ready;
    logic signed [SNR_WIDTH-1:0] snr_db;
    logic signed [SNR_WIDTH-1:0] result_snr;
    logic                        result_valid;
    logic                        result_ready;
`ifdef SNR_SEQ_THRESHOLD_EN
    logic signed [SNR_WIDTH-1:0] snr_min;
    logic                        snr_low;

    modport master (
        input  sample_valid, sample_ready, snr_db, result_ready, snr_min,
        output result_snr, result_valid, snr_low
    );
    modport slave (
        output sample_valid, sample_ready, snr_db, result_ready, snr_min,
        input  result_snr, result_valid, snr_low
    );
`else
    modport master (
        input  sample_valid, sample_ready, snr_db, result_ready,
        output result_snr, result_valid
    );
    modport slave (
        output sample_valid, sample_ready, snr_db, result_ready,
        input  result_snr, result_valid
    );
`endif
endinterface

// File: rtl/snr_window_accumulator.sv
// Signed window accumulator with shift-average output for the SNR sequencer.
// Latency: avg is combinational and already includes the current din (acc + din).
// Backpressure: none; add_en gates accumulation, clr holds the sum at zero.
// Ports: clk, reset (sync, active-high), clr, add_en, din (signed), avg (signed).
module snr_window_accumulator #(
    parameter int SNR_WIDTH   = 16,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        add_en,
    input  logic signed [SNR_WIDTH-1:0] din,
    output logic signed [SNR_WIDTH-1:0] avg
);
    // WINDOW_LOG2 guard bits: a full window of extreme samples cannot overflow.
    localparam int ACC_W = SNR_WIDTH + WINDOW_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;

    assign din_ext = {{WINDOW_LOG2{din[SNR_WIDTH-1]}}, din};
    assign sum     = acc + din_ext;

    // Arithmetic shift floors toward -inf; the quotient always fits SNR_WIDTH.
    assign avg = SNR_WIDTH'(sum >>> WINDOW_LOG2);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/snr_measurement_sequencer.sv
// Sequences SNR calculator: noise-floor calibration, settle, windowed average of snr_db.
// Latency: result_valid rises 1 cycle after the last window tick; back in MEASURE 1 cycle after handshake.
// Backpressure: result held stable while result_ready is low; ticks in REPORT are ignored.
// Optional macro SNR_SEQ_THRESHOLD_EN: bus.snr_min/bus.snr_low compare and auto re-calibration.
// Ports: clk, reset (sync, active-high), start/recal/abort pulses, continuous mode,
//        quiet_period/busy/calibrated status, bus (sample tap in, result handshake out).
module snr_measurement_sequencer
    import snr_pkg::*;
#(
    parameter int SNR_WIDTH      = 16,
    parameter int CAL_SAMPLES    = DEF_CAL_SAMPLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int WINDOW_LOG2    = DEF_WINDOW_LOG2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic recal,
    input  logic abort,
    input  logic continuous,
    output logic quiet_period,
    output logic busy,
    output logic calibrated,
    snr_measurement_sequencer_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] CAL_LAST    = CNT_WIDTH'(CAL_SAMPLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST =
        CNT_WIDTH'((SETTLE_SAMPLES > 0) ? (SETTLE_SAMPLES - 1) : 0);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST    = CNT_WIDTH'((1 << WINDOW_LOG2) - 1);

    snr_state_t                  state;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        tick;
    logic                        acc_clr;
    logic                        acc_add;
    logic signed [SNR_WIDTH-1:0] avg;
    logic signed [SNR_WIDTH-1:0] result_snr_q;
    logic                        result_valid_q;

    // Only beats the calculator actually accepts are counted.
    assign tick = bus.sample_valid & bus.sample_ready;

    // Accumulator is held at zero outside MEASURE, so every entry into
    // MEASURE (from SETTLE, CALIBRATE or REPORT) starts a fresh window.
    assign acc_clr = (state != MEASURE);
    assign acc_add = (state == MEASURE) & tick;

    snr_window_accumulator #(
        .SNR_WIDTH   (SNR_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .add_en (acc_add),
        .din    (bus.snr_db),
        .avg    (avg)
    );

    assign bus.result_snr   = result_snr_q;
    assign bus.result_valid = result_valid_q;

`ifdef SNR_SEQ_THRESHOLD_EN
    logic snr_low_q;
    assign bus.snr_low = snr_low_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            quiet_period   <= 1'b0;
            busy           <= 1'b0;
            calibrated     <= 1'b0;
            result_valid_q <= 1'b0;
            result_snr_q   <= '0;
`ifdef SNR_SEQ_THRESHOLD_EN
            snr_low_q      <= 1'b0;
`endif
        end else if (abort) begin
            // Noise floor stays valid; any pending result is simply withdrawn.
            state          <= IDLE;
            cnt            <= '0;
            quiet_period   <= 1'b0;
            busy           <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (recal && (state != IDLE)) begin
            state          <= CALIBRATE;
            cnt            <= '0;
            quiet_period   <= 1'b1;
            busy           <= 1'b1;
            calibrated     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CALIBRATE;
                        cnt          <= '0;
                        quiet_period <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                CALIBRATE: begin
                    if (tick) begin
                        if (cnt == CAL_LAST) begin
                            cnt          <= '0;
                            quiet_period <= 1'b0;
                            calibrated   <= 1'b1;
                            state        <= (SETTLE_SAMPLES == 0) ? MEASURE : SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    if (tick) begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= MEASURE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    if (tick) begin
                        if (cnt == WIN_LAST) begin
                            // avg already folds in this final sample.
                            cnt            <= '0;
                            result_snr_q   <= avg;
                            result_valid_q <= 1'b1;
                            state          <= REPORT;
`ifdef SNR_SEQ_THRESHOLD_EN
                            snr_low_q      <= (avg < bus.snr_min);
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                REPORT: begin
                    if (result_valid_q && bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        if (continuous) begin
`ifdef SNR_SEQ_THRESHOLD_EN
                            // A low reading suggests a stale noise floor: redo it.
                            if (snr_low_q) begin
                                state        <= CALIBRATE;
                                quiet_period <= 1'b1;
                            end else
`endif
                            state <= MEASURE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snr_measurement_sequencer.sv
// Self-checking bench for snr_measurement_sequencer (CAL=8, SETTLE=2, WINDOW_LOG2=2).
// Directed scenarios followed by randomized control/sample traffic, all checked
// against a window-average reference model built from queues and integer division.
module tb_snr_measurement_sequencer;

    localparam int SW   = 16;
    localparam int CAL  = 8;
    localparam int SET  = 2;
    localparam int WL   = 2;
    localparam int NWIN = 1 << WL;

    localparam int PH_IDLE = 0;
    localparam int PH_CAL  = 1;
    localparam int PH_SET  = 2;
    localparam int PH_MEAS = 3;
    localparam int PH_REP  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, recal, abort, continuous;
    logic quiet_period, busy, calibrated;

    snr_measurement_sequencer_if #(.SNR_WIDTH(SW)) sif();

    snr_measurement_sequencer #(
        .SNR_WIDTH      (SW),
        .CAL_SAMPLES    (CAL),
        .SETTLE_SAMPLES (SET),
        .WINDOW_LOG2    (WL),
        .CNT_WIDTH      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .recal        (recal),
        .abort        (abort),
        .continuous   (continuous),
        .quiet_period (quiet_period),
        .busy         (busy),
        .calibrated   (calibrated),
        .bus          (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_phase = PH_IDLE;
    int  m_n     = 0;
    int  m_win[$];
    bit  m_quiet = 0, m_busy = 0, m_cal = 0, m_rv = 0;
    int  m_res   = 0;
    bit  m_tick;
    bit  mdl_chk = 0;

    function automatic int floor_avg(int s, int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int win_sum();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return s;
    endfunction

    always @(posedge clk) begin
        m_tick = sif.sample_valid && sif.sample_ready;
        if (reset) begin
            m_phase = PH_IDLE; m_n = 0; m_win.delete();
            m_quiet = 0; m_busy = 0; m_cal = 0; m_rv = 0; m_res = 0;
        end else if (abort) begin
            m_phase = PH_IDLE; m_quiet = 0; m_busy = 0; m_rv = 0;
        end else if (recal && m_phase != PH_IDLE) begin
            m_phase = PH_CAL; m_n = 0; m_quiet = 1; m_busy = 1; m_cal = 0; m_rv = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_phase = PH_CAL; m_n = 0; m_quiet = 1; m_busy = 1;
                end
                PH_CAL: if (m_tick) begin
                    m_n++;
                    if (m_n == CAL) begin
                        m_cal = 1; m_quiet = 0; m_n = 0; m_win.delete();
                        m_phase = (SET == 0) ? PH_MEAS : PH_SET;
                    end
                end
                PH_SET: if (m_tick) begin
                    m_n++;
                    if (m_n == SET) begin
                        m_n = 0; m_win.delete(); m_phase = PH_MEAS;
                    end
                end
                PH_MEAS: if (m_tick) begin
                    m_win.push_back(int'($signed(sif.snr_db)));
                    if (m_win.size() == NWIN) begin
                        m_res = floor_avg(win_sum(), NWIN);
                        m_rv = 1; m_phase = PH_REP;
                    end
                end
                PH_REP: if (m_rv && sif.result_ready) begin
                    m_rv = 0; m_win.delete();
                    if (continuous) m_phase = PH_MEAS;
                    else begin m_phase = PH_IDLE; m_busy = 0; end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mdl_chk) begin
            check_val("quiet_period", int'(quiet_period), int'(m_quiet));
            check_val("busy", int'(busy), int'(m_busy));
            check_val("calibrated", int'(calibrated), int'(m_cal));
            check_val("result_valid", int'(sif.result_valid), int'(m_rv));
            if (m_rv) check_val("result_snr", int'($signed(sif.result_snr)), m_res);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic signed [SW-1:0] feed[$];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (m_phase == PH_MEAS && feed.size() > 0) sif.snr_db = feed.pop_front();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_rv(input int budget);
        int k = 0;
        while (!sif.result_valid && k < budget) begin step(); k++; end
        check_val("result_valid_seen", int'(sif.result_valid), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin step(); k++; end
        check_val("idle_reached", int'(busy), 0);
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int k = 0;
        while (m_phase != ph && k < budget) begin step(); k++; end
        check_val("phase_reached", m_phase, ph);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int qcnt, rvcnt, got_res, n;
        bit prev_q, prev_c;
        logic signed [SW-1:0] held;

        reset = 1; start = 0; recal = 0; abort = 0; continuous = 0;
        sif.sample_valid = 0; sif.sample_ready = 0; sif.snr_db = '0; sif.result_ready = 0;
`ifdef SNR_SEQ_THRESHOLD_EN
        sif.snr_min = 16'sh8000;
`endif
        repeat (3) step();
        reset = 0;
        step();

        check_val("rst_quiet", int'(quiet_period), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_cal", int'(calibrated), 0);
        check_val("rst_rv", int'(sif.result_valid), 0);
        check_val("rst_res", int'($signed(sif.result_snr)), 0);
        mdl_chk = 1;

        // One-shot run, ticks every cycle.
        sif.sample_valid = 1; sif.sample_ready = 1; sif.result_ready = 1; continuous = 0;
        feed = '{16'sh0A00, 16'sh0C00, 16'sh0E00, 16'sh1000};
        pulse_start();
        qcnt = int'(quiet_period); rvcnt = 0; got_res = 0; prev_q = 1; prev_c = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            qcnt += int'(quiet_period);
            if (prev_q && !quiet_period) begin
                check_val("cal_rise_now", int'(calibrated), 1);
                check_val("cal_low_before", int'(prev_c), 0);
            end
            prev_q = quiet_period; prev_c = calibrated;
            if (sif.result_valid) begin rvcnt++; got_res = int'($signed(sif.result_snr)); end
            if (!busy) break;
        end
        check_val("quiet_cycles", qcnt, CAL);
        check_val("oneshot_count", rvcnt, 1);
        check_val("avg_0d00", got_res, 32'h0D00);
        check_val("oneshot_idle", int'(busy), 0);

        // Negative rounding toward -inf.
        feed = '{-16'sd3, -16'sd3, -16'sd3, -16'sd2};
        pulse_start();
        wait_rv(60);
        check_val("avg_neg_floor", int'($signed(sif.result_snr)), -3);
        wait_idle(10);

        // Continuous mode with backpressure.
        continuous = 1; sif.result_ready = 0;
        feed = '{16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400};
        pulse_start();
        wait_rv(60);
        held = sif.result_snr;
        check_val("bp_first", int'(held), 32'h0280);
        for (int i = 0; i < 20; i++) begin
            sif.snr_db = SW'($urandom);
            step();
            check_val("bp_hold_snr", int'($signed(sif.result_snr)), int'(held));
            check_val("bp_hold_rv", int'(sif.result_valid), 1);
        end
        feed = '{16'sh1000, 16'sh1000, 16'sh1000, 16'sh1400};
        sif.result_ready = 1;
        step();
        sif.result_ready = 0;
        wait_rv(20);
        check_val("bp_second", int'($signed(sif.result_snr)), 32'h1100);

        // recal with a pending result.
        recal = 1; step(); recal = 0;
        check_val("recal_rv", int'(sif.result_valid), 0);
        check_val("recal_cal", int'(calibrated), 0);
        check_val("recal_quiet", int'(quiet_period), 1);

        // Tick gating: valid without ready freezes calibration.
        sif.sample_ready = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            check_val("gate_quiet", int'(quiet_period), 1);
        end
        sif.sample_ready = 1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(); n++;
            if (!quiet_period) break;
        end
        check_val("gate_ticks_to_cal", n, CAL);
        check_val("gate_cal_set", int'(calibrated), 1);

        // recal + abort together in MEASURE: abort wins, calibrated kept.
        wait_phase(PH_MEAS, 20);
        recal = 1; abort = 1; step(); recal = 0; abort = 0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_cal", int'(calibrated), 1);
        check_val("abort_quiet", int'(quiet_period), 0);

        // Reset while a result is pending.
        sif.result_ready = 0;
        pulse_start();
        wait_rv(60);
        reset = 1; step(); reset = 0;
        check_val("rst_rep_quiet", int'(quiet_period), 0);
        check_val("rst_rep_busy", int'(busy), 0);
        check_val("rst_rep_cal", int'(calibrated), 0);
        check_val("rst_rep_rv", int'(sif.result_valid), 0);
        check_val("rst_rep_res", int'($signed(sif.result_snr)), 0);

        // Randomized traffic and control.
        for (int i = 0; i < 4000; i++) begin
            sif.sample_valid = ($urandom_range(0, 3) != 0);
            sif.sample_ready = ($urandom_range(0, 3) != 0);
            sif.snr_db       = SW'($urandom);
            sif.result_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) continuous = ~continuous;
            start = ($urandom_range(0, 19) == 0);
            recal = ($urandom_range(0, 199) == 0);
            abort = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        start = 0; recal = 0; abort = 0; reset = 0;
        step();

        mdl_chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
